// File: rtl/case_9_pkg.sv
// Shared types and helpers for the case_9 reduction stages.
// Holds the FSM state enum, default widths and the signed clamp.
package case_9_pkg;

    localparam int C9_PROD_W = 8;
    localparam int C9_SUM_W  = 12;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Clamp a signed value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_s(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (width - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (width - 1));
        if (value > mx)
            return mx;
        else if (value < mn)
            return mn;
        else
            return value;
    endfunction

endpackage

// File: rtl/case_9_acc_8s_if.sv
// Product-in / sum-out stream bundle for the case_9 accumulator.
// slave is the accumulator side, master is the producer/consumer side.
interface case_9_acc_8s_if #(
    parameter int DIN_WIDTH  = 8,
    parameter int DOUT_WIDTH = 12,
    parameter int CNT_WIDTH  = 9
) ();

    logic [DIN_WIDTH-1:0]  din;
    logic                  din_vld;
    logic                  din_rdy;
    logic                  din_last;
    logic [DOUT_WIDTH-1:0] dout;
    logic [CNT_WIDTH-1:0]  dout_cnt;
    logic                  dout_sat;
    logic                  dout_vld;
    logic                  dout_rdy;

    modport slave (
        input  din,
        input  din_vld,
        output din_rdy,
        input  din_last,
        output dout,
        output dout_cnt,
        output dout_sat,
        output dout_vld,
        input  dout_rdy
    );

    modport master (
        output din,
        output din_vld,
        input  din_rdy,
        output din_last,
        input  dout,
        input  dout_cnt,
        input  dout_sat,
        input  dout_vld,
        output dout_rdy
    );

endinterface

// File: rtl/case_9_sat_s.sv
// Combinational signed clamp from IN_W to OUT_W bits.
// Reports whether the value had to be clamped.
module case_9_sat_s
    import case_9_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    logic signed [63:0] wide;
    logic signed [63:0] clamp;

    assign wide  = {{(64 - IN_W){din[IN_W-1]}}, din};
    assign clamp = sat_s(wide, OUT_W);
    assign dout  = clamp[OUT_W-1:0];
    assign sat   = (clamp != wide);

endmodule

// File: rtl/case_9_acc_8s.sv
// Signed accumulate-and-emit stage behind the case_9 multiplier.
// Sums a frame of products and emits a saturated sum with count.
module case_9_acc_8s
    import case_9_pkg::*;
#(
    parameter int DIN_WIDTH  = C9_PROD_W,
    parameter int DOUT_WIDTH = C9_SUM_W,
    parameter int MAX_LEN    = 256
) (
    input  logic           ap_clk,
    input  logic           ap_rst,
    case_9_acc_8s_if.slave bus
);

    localparam int CNT_WIDTH = $clog2(MAX_LEN) + 1;
    localparam int ACC_WIDTH = DIN_WIDTH + $clog2(MAX_LEN);

    state_t                       state;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic [CNT_WIDTH-1:0]         cnt;
    logic                         beat;
    logic                         close;
    logic signed [DOUT_WIDTH-1:0] sat_val;
    logic                         sat_flag;

    logic                         rdy_q;
    logic                         vld_q;
    logic [DOUT_WIDTH-1:0]        dout_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic                         sat_q;

    assign sum = acc + {{(ACC_WIDTH - DIN_WIDTH){bus.din[DIN_WIDTH-1]}}, bus.din};
    assign beat = bus.din_vld && rdy_q;
    // The MAX_LEN-th beat closes the frame even without din_last.
    assign close = beat && (bus.din_last || cnt == CNT_WIDTH'(MAX_LEN - 1));

    case_9_sat_s #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (DOUT_WIDTH)
    ) u_sat (
        .din  (sum),
        .dout (sat_val),
        .sat  (sat_flag)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state  <= ACC;
            acc    <= '0;
            cnt    <= '0;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
            dout_q <= '0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (close) begin
                        dout_q <= sat_val;
                        cnt_q  <= cnt + CNT_WIDTH'(1);
                        sat_q  <= sat_flag;
                        acc    <= '0;
                        cnt    <= '0;
                        rdy_q  <= 1'b0;
                        vld_q  <= 1'b1;
                        state  <= HOLD;
                    end else if (beat) begin
                        acc <= sum;
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (vld_q && bus.dout_rdy) begin
                        rdy_q <= 1'b1;
                        vld_q <= 1'b0;
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    assign bus.din_rdy  = rdy_q;
    assign bus.dout_vld = vld_q;
    assign bus.dout     = dout_q;
    assign bus.dout_cnt = cnt_q;
    assign bus.dout_sat = sat_q;

endmodule

// File: tb/tb_case_9_acc_8s.sv
// Directed bench for case_9_acc_8s: vector table plus corner sequences.
// Expected sums are hand-computed constants.
module tb_case_9_acc_8s;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;

    int total = 0;
    int bad   = 0;

    case_9_acc_8s_if #(.DIN_WIDTH(8), .DOUT_WIDTH(12), .CNT_WIDTH(9)) bus ();

    case_9_acc_8s dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int n;
        int v0;
        int step;
        bit last;
        bit bub;
        int e_dout;
        int e_cnt;
        bit e_sat;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic beat(input int v, input bit last, input bit bub);
        int w;
        if (bub) begin
            while ($urandom_range(0, 1) == 1) begin
                bus.din_vld = 1'b0;
                step_clk();
            end
        end
        w = 0;
        while (!bus.din_rdy && w < 20) begin
            step_clk();
            w++;
        end
        if (w == 20) begin
            total++;
            bad++;
            $display("FAIL rdy_timeout: got din_rdy=0 want 1 within 20 cycles");
        end
        bus.din      = 8'(v);
        bus.din_vld  = 1'b1;
        bus.din_last = last;
        step_clk();
        bus.din_vld  = 1'b0;
        bus.din_last = 1'b0;
    endtask

    // Called #1 after the closing edge with dout_rdy high.
    task automatic check_close(input string name, input int e_dout, input int e_cnt, input bit e_sat);
        chk({name, "_vld"}, int'(bus.dout_vld), 1);
        chk({name, "_dout"}, int'($signed(bus.dout)), e_dout);
        chk({name, "_cnt"}, int'(bus.dout_cnt), e_cnt);
        chk({name, "_sat"}, int'(bus.dout_sat), int'(e_sat));
        step_clk();
        chk({name, "_rdy_back"}, int'(bus.din_rdy), 1);
    endtask

    initial begin
        vt[0] = '{20, 127, 0, 1, 0, 2047, 20, 1};
        vt[1] = '{10, 1, 1, 1, 1, 55, 10, 0};
        vt[2] = '{3, -100, 0, 1, 0, -300, 3, 0};
        vt[3] = '{30, -100, 0, 1, 0, -2048, 30, 1};
        vt[4] = '{16, 127, 0, 1, 0, 2032, 16, 0};
        vt[5] = '{16, -128, 0, 1, 0, -2048, 16, 0};
        vt[6] = '{2, 127, -254, 1, 0, 0, 2, 0};
        vt[7] = '{17, 127, 0, 1, 1, 2047, 17, 1};

        bus.din      = '0;
        bus.din_vld  = 1'b0;
        bus.din_last = 1'b0;
        bus.dout_rdy = 1'b1;

        step_clk();
        step_clk();
        ap_rst = 1'b0;
        chk("rst_vld", int'(bus.dout_vld), 0);
        chk("rst_rdy", int'(bus.din_rdy), 1);
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_cnt", int'(bus.dout_cnt), 0);
        chk("rst_sat", int'(bus.dout_sat), 0);

        // Basic frame; din_rdy low for exactly one cycle.
        beat(3, 0, 0);
        beat(-5, 0, 0);
        beat(10, 0, 0);
        chk("f4_no_vld_early", int'(bus.dout_vld), 0);
        beat(7, 1, 0);
        chk("f4_rdy_low", int'(bus.din_rdy), 0);
        check_close("f4", 15, 4, 0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < vt[k].n; i++)
                beat(vt[k].v0 + i * vt[k].step, vt[k].last && (i == vt[k].n - 1), vt[k].bub);
            check_close($sformatf("vec%0d", k), vt[k].e_dout, vt[k].e_cnt, vt[k].e_sat);
        end

        // Forced close at MAX_LEN, then beat 257 opens a fresh frame.
        for (int i = 0; i < 255; i++)
            beat(-128, 0, 0);
        chk("max_no_vld_255", int'(bus.dout_vld), 0);
        beat(-128, 0, 0);
        check_close("max", -2048, 256, 1);
        beat(9, 1, 0);
        check_close("after_max", 9, 1, 0);

        // Consumer stall: result must hold while dout_rdy is low.
        bus.dout_rdy = 1'b0;
        beat(-1, 1, 0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d_vld", c), int'(bus.dout_vld), 1);
            chk($sformatf("hold%0d_dout", c), int'($signed(bus.dout)), -1);
            chk($sformatf("hold%0d_rdy", c), int'(bus.din_rdy), 0);
            step_clk();
        end
        bus.dout_rdy = 1'b1;
        chk("hold_c6_vld", int'(bus.dout_vld), 1);
        step_clk();
        chk("hold_rel_vld", int'(bus.dout_vld), 0);
        chk("hold_rel_rdy", int'(bus.din_rdy), 1);

        // Reset mid-frame discards the partial sum.
        beat(100, 0, 0);
        beat(100, 0, 0);
        ap_rst = 1'b1;
        step_clk();
        ap_rst = 1'b0;
        chk("mid_rst_vld", int'(bus.dout_vld), 0);
        chk("mid_rst_rdy", int'(bus.din_rdy), 1);
        step_clk();
        chk("mid_rst_vld2", int'(bus.dout_vld), 0);
        beat(5, 1, 0);
        check_close("post_rst", 5, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/case_9_acc_8s.md
# case_9_acc_8s

Signed accumulate-and-emit stage that sits directly downstream of the `case_9` 8-bit signed multiplier. It consumes one product per beat over a valid/ready stream and sums a frame terminated by `din_last`, or by reaching `MAX_LEN` beats. It then emits the frame sum, saturated to `DOUT_WIDTH`, together with a beat count and a saturation flag. The block provides the sequential reduction the combinational multiplier lacks and feeds the `case_9` result writer.

## Interface
Parameters:
- `DIN_WIDTH`, 8: width of the signed product input.
- `DOUT_WIDTH`, 12: width of the signed saturated sum output.
- `MAX_LEN`, 256: maximum beats per frame; a power of two, ≥2.
- `CNT_WIDTH` (localparam): `$clog2(MAX_LEN)+1`.
- `ACC_WIDTH` (localparam): `DIN_WIDTH + $clog2(MAX_LEN)`. This width can never overflow.

Ports:
- `ap_clk` in 1: the single clock; all logic on the rising edge.
- `ap_rst` in 1: synchronous, active-high reset.
- `din` in `DIN_WIDTH`: signed product from the multiplier.
- `din_vld` in 1: `din` and `din_last` are valid.
- `din_rdy` out 1: the block accepts a beat this cycle.
- `din_last` in 1: the beat closes the frame.
- `dout` out `DOUT_WIDTH`: signed saturated frame sum.
- `dout_cnt` out `CNT_WIDTH`: number of beats in the frame, range 1..`MAX_LEN`.
- `dout_sat` out 1: set when the sum was clamped.
- `dout_vld` out 1: the result is valid.
- `dout_rdy` in 1: the consumer accepts the result.

## Operation
- FSM states:
  - `ACC`: `din_rdy`=1, `dout_vld`=0.
  - `HOLD`: `din_rdy`=0, `dout_vld`=1.
- Input beat = `din_vld && din_rdy`. On a beat:
  - `acc <= acc + sext(din)`.
  - `cnt <= cnt + 1`.
- Frame close = beat with `din_last`=1, or beat where `cnt == MAX_LEN-1`. Forced close on the `MAX_LEN`-th beat happens regardless of `din_last`.
- On frame close:
  - Register `dout` = sat(acc + sext(din)).
  - Register `dout_cnt` = cnt + 1.
  - Register `dout_sat`.
  - Clear `acc` and `cnt`.
  - Go to `HOLD`.
- Saturation:
  - Max = 2^(DOUT_WIDTH-1)-1, min = -2^(DOUT_WIDTH-1). Defaults: 2047 / -2048.
  - Sum above max → max, `dout_sat`=1.
  - Sum below min → min, `dout_sat`=1.
  - Otherwise exact, `dout_sat`=0.
- `HOLD`:
  - `dout`, `dout_cnt`, `dout_sat` stay stable.
  - When `dout_vld && dout_rdy`, go to `ACC`.
- `din_vld`=0 cycles inside a frame are bubbles; the accumulator holds its value.
- Handshake rules:
  - `din_rdy` depends only on state, not combinationally on `din_vld`.
  - `dout_vld` never drops before acceptance.

## Timing
- Reset (`ap_rst`=1 at an edge):
  - State → `ACC`; `acc`, `cnt` → 0.
  - `dout_vld`=0, `dout`=0, `dout_cnt`=0, `dout_sat`=0.
  - `din_rdy`=1 from the first cycle after reset.
- Reset mid-frame or in `HOLD` discards the partial sum or the pending result. No output is produced for that frame.
- Latency: `dout_vld` rises on the cycle after the closing beat's edge.
- Throughput: one beat per cycle within a frame. There is a minimum one-cycle input gap per frame, because `din_rdy`=0 in `HOLD`.
  - With `dout_rdy` held at 1: frame of N beats occupies N+1 cycles.
- Back-to-back frames: the first beat of the next frame is accepted on the cycle after the result handshake.
- `din_last`=1 on the first beat gives a single-beat frame: `dout_cnt`=1.
- `din_last`=1 on the `MAX_LEN`-th beat: one close, no extra frame.

## Structure
- Shared package `case_9_pkg`:
  - State enum `{ACC, HOLD}`.
  - Saturation function `sat_s(value, width)`, also used by other `case_9` reducers.
  - Default width constants `C9_PROD_W`=8 and `C9_SUM_W`=12.
- Single optional sub-module `case_9_sat_s`: combinational clamp with parameterised in/out widths and the sat flag. The FSM, counter and accumulator stay in the top module.

## Test plan
- Reset then 4 beats (3, -5, 10, 7), `last` on the 4th, `dout_rdy`=1 → one cycle later `dout`=15, `dout_cnt`=4, `dout_sat`=0. `din_rdy`=0 for exactly one cycle.
- 20 beats of 127, `last` on the 20th → sum 2540 clamps: `dout`=2047, `dout_sat`=1, `dout_cnt`=20.
- 256 beats of -128, no `last` → forced close: `dout`=-2048, `dout_sat`=1, `dout_cnt`=256. Beat 257 starts a new frame.
- Single beat -1 with `last`, `dout_rdy` held 0 for 5 cycles → `dout_vld` stays 1 with `dout`=-1, `din_rdy`=0 throughout. Handshake on cycle 6, `ACC` on cycle 7.
- Random `din_vld` bubbles (50%) over a 10-beat frame of 1..10 → `dout`=55, `dout_cnt`=10.
- Assert `ap_rst` mid-frame after beats 100, 100 → no `dout_vld`. Next frame of 5 with `last` gives `dout`=5, `dout_cnt`=1.
